// File: rtl/obc_shift_acc.sv
// OBC bit-serial shift-accumulator: sums B ROM partial sums MSB-plane first, then adds the offset.
// Optional define OBC_ACC_SAT_EN saturates the accumulate and final add instead of wrapping.
module obc_shift_acc #(
  parameter int B     = 16,
  parameter int ACC_W = 48
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [31:0]             romout,
  input  logic [31:0]             offset,
  output logic [$clog2(B)-1:0]    bit_sel,
  output logic                    m,
  output logic                    busy,
  output logic [ACC_W-1:0]        dout,
  output logic                    dout_valid
);

  // state | meaning
  // IDLE  | waiting for start; bit_sel and m held at 0
  // ACCUM | one bit-plane per cycle, acc = 2*acc + romout
  // FINAL | add latched offset, publish dout
  typedef enum logic [1:0] {IDLE, ACCUM, FINAL} state_t;

  localparam int SW = $clog2(B);

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [31:0]      off_q;
  logic [ACC_W-1:0] acc_nxt;
  logic [ACC_W-1:0] fin_nxt;

`ifdef OBC_ACC_SAT_EN
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W+1:0] acc_wide;
  logic [ACC_W:0]   fin_wide;

  // Two guard bits hold 2*acc + romout exactly; clamp when the guards disagree with the sign.
  always_comb begin
    acc_wide = ({{2{acc[ACC_W-1]}}, acc} << 1) + {{(ACC_W+2-32){romout[31]}}, romout};
    if (acc_wide[ACC_W+1:ACC_W-1] == 3'b000 || acc_wide[ACC_W+1:ACC_W-1] == 3'b111)
      acc_nxt = acc_wide[ACC_W-1:0];
    else
      acc_nxt = acc_wide[ACC_W+1] ? ACC_MIN : ACC_MAX;
  end

  always_comb begin
    fin_wide = {acc[ACC_W-1], acc} + {{(ACC_W+1-32){off_q[31]}}, off_q};
    if (fin_wide[ACC_W] == fin_wide[ACC_W-1])
      fin_nxt = fin_wide[ACC_W-1:0];
    else
      fin_nxt = fin_wide[ACC_W] ? ACC_MIN : ACC_MAX;
  end
`else
  always_comb begin
    acc_nxt = (acc << 1) + {{(ACC_W-32){romout[31]}}, romout};
    fin_nxt = acc + {{(ACC_W-32){off_q[31]}}, off_q};
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      acc        <= '0;
      off_q      <= '0;
      bit_sel    <= '0;
      m          <= 1'b0;
      busy       <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            acc     <= '0;
            bit_sel <= SW'(B-1);
            m       <= 1'b1;
            off_q   <= offset;
            busy    <= 1'b1;
            state   <= ACCUM;
          end
        end
        ACCUM: begin
          // romout is combinational from the bit_sel/m driven right now
          acc <= acc_nxt;
          m   <= 1'b0;
          if (bit_sel == '0)
            state <= FINAL;
          else
            bit_sel <= bit_sel - 1'b1;
        end
        FINAL: begin
          dout       <= fin_nxt;
          dout_valid <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_obc_shift_acc.sv
// Self-checking bench for obc_shift_acc (B=16, ACC_W=40); expectations follow OBC_ACC_SAT_EN when defined.
module tb_obc_shift_acc;
  localparam int B     = 16;
  localparam int ACC_W = 40;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic [31:0]          romout;
  logic [31:0]          offset = '0;
  logic [$clog2(B)-1:0] bit_sel;
  logic                 m;
  logic                 busy;
  logic [ACC_W-1:0]     dout;
  logic                 dout_valid;

  int          plane_tab [B];
  int          off_v = 0;
  logic        use_rand = 1'b1;
  logic [31:0] rand_rom = '0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  // ROM stage stand-in: partial sum for whichever plane the DUT selects
  assign romout = use_rand ? rand_rom : plane_tab[bit_sel];

  obc_shift_acc #(.B(B), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .start(start), .romout(romout), .offset(offset),
    .bit_sel(bit_sel), .m(m), .busy(busy), .dout(dout), .dout_valid(dout_valid)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Result = sum of plane[p] * 2^p plus offset, reduced to ACC_W bits (or clamped per step).
  function automatic logic [ACC_W-1:0] model_result();
`ifdef OBC_ACC_SAT_EN
    longint hi = (longint'(1) <<< (ACC_W-1)) - 1;
    longint lo = -(longint'(1) <<< (ACC_W-1));
    longint a = 0;
    for (int p = B-1; p >= 0; p--) begin
      a = a * 2 + longint'(plane_tab[p]);
      if (a > hi) a = hi;
      if (a < lo) a = lo;
    end
    a = a + longint'(off_v);
    if (a > hi) a = hi;
    if (a < lo) a = lo;
    return ACC_W'(a);
`else
    longint s = 0;
    for (int p = 0; p < B; p++) s += longint'(plane_tab[p]) * (longint'(1) <<< p);
    s += longint'(off_v);
    return ACC_W'(s);
`endif
  endfunction

  task automatic run_op(input bit poke_final);
    logic [ACC_W-1:0] exp;
    int n;
    exp = model_result();
    @(negedge clk);
    start  = 1'b1;
    offset = off_v;
    @(posedge clk); #1;
    start = 1'b0;
    chk("accept_busy", busy, 1);
    chk("accept_bit_sel", bit_sel, B-1);
    chk("accept_m", m, 1);
    n = 0;
    while (!dout_valid && n < 40) begin
      if (n > 0 && n < B) begin
        chk("plane_m", m, 0);
        chk("plane_bit_sel", bit_sel, B-1-n);
      end
      if (poke_final && n == B) start = 1'b1;
      @(posedge clk); #1;
      n++;
      if (poke_final && n == B+1) start = 1'b0;
    end
    chk("latency", n, B+1);
    chk("dout", dout, exp);
    chk("busy_done", busy, 0);
    chk("idle_bit_sel", bit_sel, 0);
    chk("idle_m", m, 0);
    @(posedge clk); #1;
    chk("valid_one_cycle", dout_valid, 0);
    chk("dout_hold", dout, exp);
    if (poke_final) chk("final_start_ignored", busy, 0);
  endtask

  initial begin
    logic [ACC_W-1:0] c;
    int pos [$];
    int n;
    int seen;

    // reset with random inputs, checked between clock edges too
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start    = 1'($urandom);
      rand_rom = $urandom;
      offset   = $urandom;
      #2;
      chk("rst_dout", dout, 0);
      chk("rst_valid", dout_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_m", m, 0);
      chk("rst_bit_sel", bit_sel, 0);
    end
    @(negedge clk);
    start = 1'b0;
    use_rand = 1'b0;
    rst = 1'b0;

    // constant ones
    for (int p = 0; p < B; p++) plane_tab[p] = 1;
    off_v = 0;
    run_op(1'b0);
    chk("const_65535", dout, 65535);

    // sign plane only
    for (int p = 0; p < B; p++) plane_tab[p] = 0;
    plane_tab[B-1] = -1;
    off_v = 5;
    run_op(1'b0);
    c = -32763;
    chk("sign_plane", dout, c);

    // start raised in FINAL cycle must not restart
    for (int p = 0; p < B; p++) plane_tab[p] = p * 3 - 7;
    off_v = -100;
    run_op(1'b1);

    // start held high: one result per B+2 cycles
    for (int p = 0; p < B; p++) plane_tab[p] = 2;
    off_v = 1;
    c = model_result();
    @(negedge clk);
    start  = 1'b1;
    offset = off_v;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (dout_valid) begin
        pos.push_back(i);
        chk("held_dout", dout, c);
      end
    end
    start = 1'b0;
    chk("held_count", pos.size(), 3);
    if (pos.size() == 3) begin
      chk("held_first", pos[0], B+1);
      chk("held_period1", pos[1] - pos[0], B+2);
      chk("held_period2", pos[2] - pos[1], B+2);
    end
    repeat (2*(B+2)) @(posedge clk);

    // reset mid-accumulation
    for (int p = 0; p < B; p++) plane_tab[p] = 1;
    off_v = 0;
    @(negedge clk);
    start  = 1'b1;
    offset = off_v;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (bit_sel !== 4'd7 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reach_bit_sel7", bit_sel, 7);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_bit_sel", bit_sel, 0);
    chk("midrst_m", m, 0);
    chk("midrst_dout", dout, 0);
    #2 rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (dout_valid) seen++;
    end
    chk("midrst_no_valid", seen, 0);
    run_op(1'b0);
    chk("after_rst_65535", dout, 65535);

    // overflow of full-scale planes
    for (int p = 0; p < B; p++) plane_tab[p] = 32'h7FFFFFFF;
    off_v = 0;
    run_op(1'b0);
`ifdef OBC_ACC_SAT_EN
    chk("overflow_sat", dout, 40'h7FFFFFFFFF);
`else
    chk("overflow_wrap", dout, 40'hFF7FFF0001);
`endif

    // random planes and offsets
    for (int k = 0; k < 6; k++) begin
      for (int p = 0; p < B; p++) plane_tab[p] = (k < 3) ? int'($urandom) : int'($urandom_range(0, 2000)) - 1000;
      off_v = $urandom;
      run_op(1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
